// File: rtl/csr_access_sequencer_pkg.sv
// Shared constants and types for the phoeniX machine-mode CSR access sequencer:
// SYSTEM opcode and CSRRx funct3 encodings, CSR addresses, FSM state encoding
// and the latched request record.
package csr_access_sequencer_pkg;

  // Instruction encodings
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_CSRRW   = 3'b001;
  localparam logic [2:0] F3_CSRRS   = 3'b010;
  localparam logic [2:0] F3_CSRRC   = 3'b011;
  localparam logic [2:0] F3_CSRRWI  = 3'b101;
  localparam logic [2:0] F3_CSRRSI  = 3'b110;
  localparam logic [2:0] F3_CSRRCI  = 3'b111;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [11:0] addr;
    logic [31:0] rs1;
    logic [4:0]  uimm;
    logic        src_zero;
  } req_t;

  // True for the six CSRRx encodings (000 and 100 are not CSR accesses).
  function automatic logic is_csr_funct3(input logic [2:0] f3);
    return (f3[1:0] != 2'b00);
  endfunction

  // Set/clear forms (CSRRS/CSRRC/CSRRSI/CSRRCI) skip the write with a zero source.
  function automatic logic is_set_clear(input logic [2:0] f3);
    return f3[1];
  endfunction

endpackage

// File: rtl/csr_access_sequencer_counter64.sv
// csr_counter64: 64-bit free-running counter with increment enable and
// 32-bit half-word write. A write to either half replaces that cycle's
// increment; the other half keeps its pre-increment value.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  // Next-state selection: half write beats increment.
  always_comb begin
    count_d = count_q;
    if (wr_lo_i)      count_d = {count_q[63:32], wdata_i};
    else if (wr_hi_i) count_d = {wdata_i, count_q[31:0]};
    else if (inc_i)   count_d = count_q + 64'd1;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_access_sequencer.sv
// csr_access_sequencer: machine-mode CSR file and IDLE/EXEC/COMMIT access
// sequencer for the phoeniX core. Trap entry has priority over instruction
// accesses and is committed in a single IDLE cycle. Read-modify-write math is
// done by the external CSR unit through the unit_* ports.
// Optional feature: define PHOENIX_CSR_COUNTERS_EN to add mcycle/minstret.
module csr_access_sequencer
  import csr_access_sequencer_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_rs1,
  input  logic [4:0]  req_uimm,
  input  logic        req_src_zero,
  output logic        resp_valid,
  output logic [31:0] resp_rd,
  output logic        resp_illegal,
  output logic [6:0]  unit_opcode,
  output logic [2:0]  unit_funct3,
  output logic [31:0] unit_csr_in,
  output logic [31:0] unit_rs1,
  output logic [4:0]  unit_uimm,
  input  logic [31:0] unit_csr_out,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  output logic        trap_ack,
  output logic [31:0] trap_target,
  input  logic        retire
);

  state_e      state_q;
  req_t        req_q;
  logic [31:0] new_q;
  logic        wr_en_q;
  logic        resp_valid_q;
  logic [31:0] resp_rd_q;
  logic        resp_illegal_q;
  logic [31:0] mstatus_q, mtvec_q, mscratch_q, mepc_q, mcause_q;

  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        suppress_c;
  logic        illegal_c;
  logic        in_exec;
  logic        idle_live;

`ifdef PHOENIX_CSR_COUNTERS_EN
  logic [63:0] mcycle_cnt;
  logic [63:0] minstret_cnt;
  logic        commit_wr;
  logic        unused_ok;

  assign commit_wr = (state_q == ST_COMMIT) && wr_en_q;

  csr_counter64 u_mcycle (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (1'b1),
    .wr_lo_i (commit_wr && (req_q.addr == CSR_MCYCLE)),
    .wr_hi_i (commit_wr && (req_q.addr == CSR_MCYCLEH)),
    .wdata_i (new_q),
    .count_o (mcycle_cnt)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (retire),
    .wr_lo_i (commit_wr && (req_q.addr == CSR_MINSTRET)),
    .wr_hi_i (commit_wr && (req_q.addr == CSR_MINSTRETH)),
    .wdata_i (new_q),
    .count_o (minstret_cnt)
  );

  assign unused_ok = ^trap_pc[1:0];
`else
  logic unused_ok;
  assign unused_ok = ^{trap_pc[1:0], retire};
`endif

  // Read mux for the latched address, plus legality and write suppression.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    csr_rdata = '0;
    csr_hit   = 1'b0;
    case (req_q.addr)
      CSR_MSTATUS:   begin csr_rdata = mstatus_q;           csr_hit = 1'b1; end
      CSR_MTVEC:     begin csr_rdata = mtvec_q;             csr_hit = 1'b1; end
      CSR_MSCRATCH:  begin csr_rdata = mscratch_q;          csr_hit = 1'b1; end
      CSR_MEPC:      begin csr_rdata = mepc_q;              csr_hit = 1'b1; end
      CSR_MCAUSE:    begin csr_rdata = mcause_q;            csr_hit = 1'b1; end
      CSR_MHARTID:   begin csr_rdata = HART_ID;             csr_hit = 1'b1; end
`ifdef PHOENIX_CSR_COUNTERS_EN
      CSR_MCYCLE:    begin csr_rdata = mcycle_cnt[31:0];    csr_hit = 1'b1; end
      CSR_MCYCLEH:   begin csr_rdata = mcycle_cnt[63:32];   csr_hit = 1'b1; end
      CSR_MINSTRET:  begin csr_rdata = minstret_cnt[31:0];  csr_hit = 1'b1; end
      CSR_MINSTRETH: begin csr_rdata = minstret_cnt[63:32]; csr_hit = 1'b1; end
`endif
      default: ;
    endcase
    suppress_c = is_set_clear(req_q.funct3) && req_q.src_zero;
    illegal_c  = !csr_hit
              || (req_q.opcode != OPC_SYSTEM)
              || !is_csr_funct3(req_q.funct3)
              || ((req_q.addr == CSR_MHARTID) && !suppress_c);
  end

  assign in_exec   = (state_q == ST_EXEC);
  assign idle_live = (state_q == ST_IDLE) && !reset;

  assign req_ready    = idle_live && !trap_valid;
  assign trap_ack     = idle_live && trap_valid;
  assign trap_target  = trap_ack ? mtvec_q : '0;
  assign resp_valid   = resp_valid_q;
  assign resp_rd      = resp_rd_q;
  assign resp_illegal = resp_illegal_q;

  assign unit_opcode = in_exec ? req_q.opcode : '0;
  assign unit_funct3 = in_exec ? req_q.funct3 : '0;
  assign unit_csr_in = in_exec ? csr_rdata    : '0;
  assign unit_rs1    = in_exec ? req_q.rs1    : '0;
  assign unit_uimm   = in_exec ? req_q.uimm   : '0;

  // Sequencer FSM with CSR storage, trap commit and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      req_q          <= '0;
      new_q          <= '0;
      wr_en_q        <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rd_q      <= '0;
      resp_illegal_q <= 1'b0;
      mstatus_q      <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        ST_IDLE: begin
          if (trap_valid) begin
            mepc_q   <= {trap_pc[31:2], 2'b00};
            mcause_q <= trap_cause;
          end else if (req_valid) begin
            req_q <= '{opcode:   req_opcode,
                       funct3:   req_funct3,
                       addr:     req_addr,
                       rs1:      req_rs1,
                       uimm:     req_uimm,
                       src_zero: req_src_zero};
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          new_q          <= unit_csr_out;
          wr_en_q        <= !illegal_c && !suppress_c;
          resp_rd_q      <= illegal_c ? '0 : csr_rdata;
          resp_illegal_q <= illegal_c;
          resp_valid_q   <= 1'b1;
          state_q        <= ST_COMMIT;
        end
        ST_COMMIT: begin
          if (wr_en_q) begin
            case (req_q.addr)
              CSR_MSTATUS:  mstatus_q  <= new_q;
              CSR_MTVEC:    mtvec_q    <= new_q;
              CSR_MSCRATCH: mscratch_q <= new_q;
              CSR_MEPC:     mepc_q     <= {new_q[31:2], 2'b00};
              CSR_MCAUSE:   mcause_q   <= new_q;
              default: ;
            endcase
          end
          resp_valid_q   <= 1'b0;
          resp_illegal_q <= 1'b0;
          state_q        <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/csr_access_sequencer.md
# csr_access_sequencer

Machine-mode CSR file and access sequencer for the phoeniX core. Accepts one CSR instruction at a time from the execute stage, reads the addressed register, and drives the combinational CSR read-modify-write unit. It commits the unit's result and returns the old value for `rd`. It also arbitrates trap entry (writes `mepc` and `mcause`, returns `mtvec`) against instruction accesses, with trap priority.

## Interface
Parameters:
- `HART_ID`, 0: value returned by `mhartid`.
- `MTVEC_RESET`, 32'h0000_0000: reset value of `mtvec`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: CSR instruction request.
- `req_ready` out 1: request accepted this cycle.
- `req_opcode` in 7, `req_funct3` in 3: instruction fields.
- `req_addr` in 12: CSR address.
- `req_rs1` in 32: rs1 value.
- `req_uimm` in 5: zimm field.
- `req_src_zero` in 1: rs1 index or zimm is zero.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rd` out 32: old CSR value.
- `resp_illegal` out 1: access faulted.
- `unit_opcode` out 7, `unit_funct3` out 3, `unit_csr_in` out 32, `unit_rs1` out 32, `unit_uimm` out 5: drive to the CSR RMW unit.
- `unit_csr_out` in 32: new value from the CSR RMW unit.
- `trap_valid` in 1: trap request, held until acknowledged.
- `trap_pc` in 32: faulting PC.
- `trap_cause` in 32: cause code.
- `trap_ack` out 1: trap committed.
- `trap_target` out 32: `mtvec` value returned on acknowledge.
- `retire` in 1: instruction retired pulse.

## Operation
- Implemented CSRs:
  - `mstatus` 0x300
  - `mtvec` 0x305
  - `mscratch` 0x340
  - `mepc` 0x341, with bits [1:0] forced to 0
  - `mcause` 0x342
  - `mhartid` 0xF14, read-only
- All implemented CSRs reset to 0, except `mtvec` = `MTVEC_RESET`.
- FSM states:
  - **IDLE**
    - `trap_valid` takes priority: `trap_ack`=1 and `trap_target`=`mtvec` this cycle; `mepc`←`trap_pc`, `mcause`←`trap_cause` at the edge; stay in IDLE.
    - Otherwise `req_ready`=1. If `req_valid`, latch all request fields and go to EXEC.
  - **EXEC**
    - Drive the `unit_*` outputs from the latches; `unit_csr_in` = the addressed CSR's current value.
    - Register `unit_csr_out` and the old value; go to COMMIT.
  - **COMMIT**
    - Write the registered new value unless the write is suppressed.
    - Pulse `resp_valid` with `resp_rd` = old value; go to IDLE.
- Write suppression:
  - CSRRS, CSRRC, CSRRSI and CSRRCI with `req_src_zero`=1 do not write.
  - `mhartid` accepts no writes.
- Illegal access, reported in COMMIT as `resp_illegal`=1, `resp_rd`=0, no write:
  - unimplemented address;
  - write to `mhartid` that is not suppressed;
  - `req_opcode` not SYSTEM;
  - `req_funct3` not one of the six CSR encodings.
- A trap arriving in EXEC or COMMIT waits; it is taken in the next IDLE cycle, ahead of any pending `req_valid`.
- `unit_*` outputs are 0 outside EXEC.

## Timing
- Reset values: `req_ready`, `resp_valid`, `resp_illegal`, `trap_ack` = 0; `resp_rd`, `trap_target` = 0; FSM in IDLE. `req_ready` rises in the first cycle after reset deasserts.
- Request latency:
  - accept at cycle N;
  - `resp_valid` at N+2;
  - next acceptance at N+3 at the earliest.
  - Throughput is one access per 3 cycles.
- `req_ready` is combinational: `state==IDLE && !trap_valid`.
- `trap_ack` is combinational in IDLE and completes in one cycle. The CSR write lands at the same edge.
- Reset asserted mid-access aborts the access: no write and no response.

## Configuration
- `PHOENIX_CSR_COUNTERS_EN` defined:
  - Adds 64-bit counters with CSRs `mcycle` 0xB00, `mcycleh` 0xB80, `minstret` 0xB02, `minstreth` 0xB82, all reset to 0.
  - `mcycle` increments every cycle; `minstret` increments when `retire`=1.
  - Both wrap from all-ones to 0.
  - A COMMIT write to either half overrides that cycle's increment for the whole counter. The other half keeps its pre-increment value.
  - Reads in EXEC see the value in that cycle.
- `PHOENIX_CSR_COUNTERS_EN` undefined: these addresses are illegal and `retire` is ignored.

## Structure
- Shared package/defines (alongside the existing opcode/funct3 defines):
  - CSR address constants;
  - FSM state encoding (IDLE, EXEC, COMMIT);
  - CSR opcode/funct3 encodings, reusing the existing SYSTEM/CSRRx defines.
- One natural sub-module: `csr_counter64`, a 64-bit counter with increment enable and half-word write, instantiated twice under the macro.
- The RMW arithmetic stays in the existing external CSR unit and is not duplicated.

## Test plan
- Reset: `mtvec` reads `MTVEC_RESET`; CSRRS x0 of 0x300 returns 0 at N+2 and `mstatus` stays 0.
- CSRRW 0x340 with rs1=0xDEADBEEF → `resp_rd`=0. A following CSRRC with rs1=0x0000FFFF → `resp_rd`=0xDEADBEEF, then `mscratch`=0xDEAD0000.
- CSRRWI to 0xF14 → `resp_illegal`=1 and `mhartid` unchanged. Read of 0x7C0 → illegal, `resp_rd`=0.
- `trap_valid` with `trap_pc`=0x1003, `trap_cause`=0xB raised during EXEC → `trap_ack` in the IDLE cycle after COMMIT. `mepc`=0x1000, `mcause`=0xB, a concurrent `req_valid` stalls one cycle.
- With the macro: write `mcycle`=0xFFFFFFFF and `mcycleh`=0xFFFFFFFF, then idle 2 cycles → `mcycle` reads small and wrapped, `mcycleh`=0. `retire` pulsed 3 times → `minstret`=3.
- Without the macro: access to 0xB00 → `resp_illegal`=1.
